// File: rtl/mem_hs_be_pkg.sv
// rtl/mem_hs_be_pkg.sv - shared types and constants for the handshaked byte-enable memory
//
// Package mem_hs_pkg
//   state_t  : controller states IDLE / WAIT / RESP
//   DEF_*    : default data width, address width and depth
//   be_count : number of byte lanes for a given data width
package mem_hs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DEPTH  = 1024;

  function automatic int be_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_hs_be_array.sv
// rtl/mem_hs_be_array.sv - DEPTH x DATA_W storage with byte-enable write and registered read
//
// Module mem_array_be
//   CLK, reset          : clock, synchronous active-high reset
//   boot_word0/1        : values forced into words 0 and 1 while reset is high
//   en                  : perform one access on this edge
//   we, in_range        : write select; address lies inside the array
//   idx                 : word index (only meaningful when in_range)
//   wdata, be           : write data and per-byte enables
//   rdata               : registered read data, 0 after writes and out-of-range accesses
module mem_array_be
  import mem_hs_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int IDX_W  = 10
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             boot_word0,
  input  logic [DATA_W-1:0]             boot_word1,
  input  logic                          en,
  input  logic                          we,
  input  logic                          in_range,
  input  logic [IDX_W-1:0]              idx,
  input  logic [DATA_W-1:0]             wdata,
  input  logic [be_count(DATA_W)-1:0]   be,
  output logic [DATA_W-1:0]             rdata
);

  localparam int BE_W = be_count(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // Only the two boot words are touched by reset; the rest keep their contents.
  always_ff @(posedge CLK) begin
    if (reset) begin
      mem[0] <= boot_word0;
      mem[1] <= boot_word1;
    end else if (en && we && in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // rdata only changes on an access, so it stays stable while a response waits.
  always_ff @(posedge CLK) begin
    if (reset) begin
      rdata <= '0;
    end else if (en) begin
      if (we || !in_range) begin
        rdata <= '0;
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/mem_hs_be.sv
// rtl/mem_hs_be.sv - valid/ready front end for the byte-enable data/program memory
//
// Module mem_hs_be
//   CLK, reset              : clock, synchronous active-high reset
//   req_valid / req_ready   : request handshake
//   req_write, req_addr     : 1 = write; word address
//   req_wdata, req_be       : write data; byte enables (bit i covers byte i)
//   rsp_valid / rsp_ready   : response handshake
//   rsp_rdata, rsp_err      : read data (0 for writes/errors); address >= DEPTH
//   busy                    : controller in WAIT or RESP
module mem_hs_be
  import mem_hs_pkg::*;
#(
  parameter int              DATA_W      = DEF_DATA_W,
  parameter int              ADDR_W      = DEF_ADDR_W,
  parameter int              DEPTH       = DEF_DEPTH,
  parameter int              WAIT_CYCLES = 1,
  parameter logic [DATA_W-1:0] BOOT_WORD0 = 16'h27E7,
  parameter logic [DATA_W-1:0] BOOT_WORD1 = 16'h27E7
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  input  logic [be_count(DATA_W)-1:0]   req_be,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err,
  output logic                          busy
);

  localparam int BE_W  = be_count(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t              state;
  logic [3:0]          wait_cnt;
  logic                lat_write;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [BE_W-1:0]     lat_be;

  logic                accept;
  logic                acc_now;
  logic                acc_write;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic [BE_W-1:0]     acc_be;
  logic                acc_in_range;

  assign req_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;

  // With zero wait states the access happens on the accept edge, so the
  // array must see the live request rather than the latched copy.
  assign acc_now = ((state == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                   ((state == WAIT) && (wait_cnt == 4'd0) && !reset);

  always_comb begin
    acc_write = lat_write;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    acc_be    = lat_be;
    if (state == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end
  end

  // Full-width compare: out-of-range addresses are never folded onto the array.
  assign acc_in_range = ({1'b0, acc_addr} < DEPTH_X);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= !acc_in_range;
            end else begin
              wait_cnt <= WAIT_LOAD;
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= !acc_in_range;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_array_be #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .CLK        (CLK),
    .reset      (reset),
    .boot_word0 (BOOT_WORD0),
    .boot_word1 (BOOT_WORD1),
    .en         (acc_now),
    .we         (acc_write),
    .in_range   (acc_in_range),
    .idx        (acc_addr[IDX_W-1:0]),
    .wdata      (acc_wdata),
    .be         (acc_be),
    .rdata      (rsp_rdata)
  );

endmodule

// File: tb/tb_mem_hs_be.sv
// tb/tb_mem_hs_be.sv - scoreboard bench for mem_hs_be at WAIT_CYCLES 1, 3 and 0
module tb_mem_hs_be;

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [2:0]  reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_write;
  logic [2:0]  rsp_ready;
  logic [15:0] req_addr  [3];
  logic [15:0] req_wdata [3];
  logic [1:0]  req_be    [3];
  wire  [2:0]  req_ready;
  wire  [2:0]  rsp_valid;
  wire  [2:0]  rsp_err;
  wire  [2:0]  busy;
  wire  [15:0] rsp_rdata [3];

  int compared   = 0;
  int mismatched = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  logic [15:0] a6 [4] = '{16'd3, 16'd0, 16'd1, 16'd3};
  logic [15:0] e6 [4] = '{16'h1234, 16'h27E7, 16'h27E7, 16'h1234};

  // Instance 0: WAIT_CYCLES=1, instance 1: WAIT_CYCLES=3, instance 2: WAIT_CYCLES=0
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_hs_be #(
      .DATA_W      (16),
      .ADDR_W      (16),
      .DEPTH       (1024),
      .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 3 : 0)),
      .BOOT_WORD0  (16'h27E7),
      .BOOT_WORD1  (16'h27E7)
    ) u_dut (
      .CLK       (CLK),
      .reset     (reset[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_be    (req_be[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g]),
      .busy      (busy[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int k, input logic [15:0] er, input logic ee);
    exp_t e;
    e.rdata = er;
    e.err   = ee;
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Monitor: a response is consumed on the edge after a negedge that sees valid && ready.
  always @(negedge CLK) begin
    exp_t e;
    bit   have;
    for (int k = 0; k < 3; k++) begin
      if (!reset[k] && rsp_valid[k] && rsp_ready[k]) begin
        have = 1'b0;
        e    = '0;
        case (k)
          0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        compared++;
        if (!have) begin
          mismatched++;
          $display("FAIL rsp_unexpected inst%0d: got rdata=%h err=%b, expected no response",
                   k, rsp_rdata[k], rsp_err[k]);
        end else if (rsp_rdata[k] !== e.rdata || rsp_err[k] !== e.err) begin
          mismatched++;
          $display("FAIL rsp_data inst%0d: got rdata=%h err=%b, expected rdata=%h err=%b",
                   k, rsp_rdata[k], rsp_err[k], e.rdata, e.err);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic do_req(input int k, input bit wr, input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] b, input bit push, input logic [15:0] er,
                        input bit ee, output time t);
    int n;
    n = 0;
    if (push) push_exp(k, er, ee);
    req_write[k] = wr;
    req_addr[k]  = a;
    req_wdata[k] = d;
    req_be[k]    = b;
    req_valid[k] = 1'b1;
    forever begin
      @(negedge CLK);
      if (req_ready[k]) break;
      n++;
      if (n > 40) begin
        chk("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge CLK);
    t = $time;
    #1;
    req_valid[k] = 1'b0;
  endtask

  // Counts edges from the accept edge (inclusive) until rsp_valid is seen, then
  // moves past the next edge (the handshake edge when rsp_ready is high).
  task automatic wait_rsp(input int k, output int lat);
    lat = 0;
    forever begin
      @(negedge CLK);
      lat++;
      if (rsp_valid[k]) break;
      if (lat > 40) begin
        chk("rsp_timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge CLK);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic xact(input int k, input bit wr, input logic [15:0] a, input logic [15:0] d,
                      input logic [1:0] b, input logic [15:0] er, input bit ee,
                      input int exp_lat, input string nm, output time t);
    int lat;
    do_req(k, wr, a, d, b, 1'b1, er, ee, t);
    wait_rsp(k, lat);
    chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    time t;
    time t_prev;
    int  lat;

    reset     = 3'b111;
    req_valid = 3'b000;
    req_write = 3'b000;
    rsp_ready = 3'b111;
    for (int k = 0; k < 3; k++) begin
      req_addr[k]  = '0;
      req_wdata[k] = '0;
      req_be[k]    = '0;
    end

    // Reset state, two reset edges
    @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      chk("rst_req_ready", 32'(req_ready[k]), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      chk("rst_busy",      32'(busy[k]),      32'd0);
      chk("rst_rsp_err",   32'(rsp_err[k]),   32'd0);
      chk("rst_rsp_rdata", 32'(rsp_rdata[k]), 32'd0);
    end
    @(posedge CLK);
    #1;
    reset = 3'b000;
    @(negedge CLK);
    for (int k = 0; k < 3; k++) chk("post_rst_req_ready", 32'(req_ready[k]), 32'd1);
    @(posedge CLK);
    #1;

    // 1: boot words, WAIT_CYCLES=1 latency
    xact(0, 1'b0, 16'd0, 16'h0, 2'b00, 16'h27E7, 1'b0, 2, "t1_rd0", t);
    xact(0, 1'b0, 16'd1, 16'h0, 2'b00, 16'h27E7, 1'b0, 2, "t1_rd1", t);

    // 2: byte-enable writes
    xact(0, 1'b1, 16'd5, 16'hABCD, 2'b11, 16'h0000, 1'b0, 2, "t2_wr11", t);
    xact(0, 1'b1, 16'd5, 16'h0012, 2'b01, 16'h0000, 1'b0, 2, "t2_wr01", t);
    xact(0, 1'b0, 16'd5, 16'h0000, 2'b00, 16'hAB12, 1'b0, 2, "t2_rd5", t);

    // 3: out of range and top in-range word
    xact(0, 1'b0, 16'd1024, 16'h0000, 2'b00, 16'h0000, 1'b1, 2, "t3_rd1024", t);
    xact(0, 1'b1, 16'd1024, 16'hFFFF, 2'b11, 16'h0000, 1'b1, 2, "t3_wr1024", t);
    xact(0, 1'b0, 16'd0,    16'h0000, 2'b00, 16'h27E7, 1'b0, 2, "t3_rd0", t);
    xact(0, 1'b1, 16'd1023, 16'h0BEE, 2'b11, 16'h0000, 1'b0, 2, "t3_wr1023", t);
    xact(0, 1'b0, 16'd1023, 16'h0000, 2'b00, 16'h0BEE, 1'b0, 2, "t3_rd1023", t);

    // 4: back-pressure on the response; a request pulse must be ignored
    rsp_ready[0] = 1'b0;
    do_req(0, 1'b0, 16'd5, 16'h0000, 2'b00, 1'b1, 16'hAB12, 1'b0, t);
    wait_rsp(0, lat);
    chk("t4_lat", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        req_write[0] = 1'b1;
        req_addr[0]  = 16'd5;
        req_wdata[0] = 16'h0000;
        req_be[0]    = 2'b11;
        req_valid[0] = 1'b1;
      end
      @(negedge CLK);
      chk("t4_rsp_valid", 32'(rsp_valid[0]), 32'd1);
      chk("t4_rsp_rdata", 32'(rsp_rdata[0]), 32'h0000AB12);
      chk("t4_req_ready", 32'(req_ready[0]), 32'd0);
      @(posedge CLK);
      #1;
      req_valid[0] = 1'b0;
    end
    rsp_ready[0] = 1'b1;
    @(posedge CLK);
    #1;
    xact(0, 1'b0, 16'd5, 16'h0000, 2'b00, 16'hAB12, 1'b0, 2, "t4_rd5", t);

    // Extra byte-enable patterns: none and upper byte only
    xact(0, 1'b1, 16'd5, 16'hFFFF, 2'b00, 16'h0000, 1'b0, 2, "be00_wr", t);
    xact(0, 1'b0, 16'd5, 16'h0000, 2'b00, 16'hAB12, 1'b0, 2, "be00_rd", t);
    xact(0, 1'b1, 16'd5, 16'h3499, 2'b10, 16'h0000, 1'b0, 2, "be10_wr", t);
    xact(0, 1'b0, 16'd5, 16'h0000, 2'b00, 16'h3412, 1'b0, 2, "be10_rd", t);

    // 5: reset during WAIT drops the write (WAIT_CYCLES=3)
    xact(1, 1'b1, 16'd7, 16'h5A5A, 2'b11, 16'h0000, 1'b0, 4, "t5_wr_prior", t);
    do_req(1, 1'b1, 16'd7, 16'h1111, 2'b11, 1'b0, 16'h0000, 1'b0, t);
    @(negedge CLK);
    chk("t5_busy_wait", 32'(busy[1]), 32'd1);
    chk("t5_req_ready_wait", 32'(req_ready[1]), 32'd0);
    @(posedge CLK);
    #1;
    reset[1] = 1'b1;
    @(posedge CLK);
    #1;
    reset[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("t5_no_rsp", 32'(rsp_valid[1]), 32'd0);
      chk("t5_idle",   32'(busy[1]),      32'd0);
      @(posedge CLK);
      #1;
    end
    xact(1, 1'b0, 16'd7, 16'h0000, 2'b00, 16'h5A5A, 1'b0, 4, "t5_rd7", t);

    // 6: WAIT_CYCLES=0, back-to-back reads every 2 cycles
    xact(2, 1'b1, 16'd3, 16'h1234, 2'b11, 16'h0000, 1'b0, 1, "t6_wr3", t);
    t_prev = t;
    for (int i = 0; i < 4; i++) begin
      xact(2, 1'b0, a6[i], 16'h0000, 2'b00, e6[i], 1'b0, 1, "t6_rd", t);
      chk("t6_spacing", 32'(t - t_prev), 32'd20);
      t_prev = t;
    end

    repeat (3) @(posedge CLK);
    #1;
    chk("queues_empty", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
